// File: rtl/md5_block_reader.sv
// md5_block_reader: AXI4 read front-end fetching 64-byte blocks and streaming them to the MD5 core.
// Define MD5_RD_PERF_EN to add the perf_ar_stall/perf_credit_stall/perf_out_stall counters.
module md5_block_reader #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 512,
    parameter int ID_W       = 16,
    parameter int MAX_BURST  = 64,
    parameter int FIFO_DEPTH = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [31:0]       num_blocks,
    output logic              busy,
    output logic              done,
    output logic              rd_err,
    output logic [ID_W-1:0]   arid_m,
    output logic [ADDR_W-1:0] araddr_m,
    output logic [7:0]        arlen_m,
    output logic [2:0]        arsize_m,
    output logic              arvalid_m,
    input  logic              arready_m,
    input  logic [ID_W-1:0]   rid_m,
    input  logic [DATA_W-1:0] rdata_m,
    input  logic [1:0]        rresp_m,
    input  logic              rlast_m,
    input  logic              rvalid_m,
    output logic              rready_m,
    output logic [DATA_W-1:0] blk_data,
    output logic              blk_valid,
    output logic              blk_last,
`ifdef MD5_RD_PERF_EN
    output logic [31:0]       perf_ar_stall,
    output logic [31:0]       perf_credit_stall,
    output logic [31:0]       perf_out_stall,
`endif
    input  logic              blk_ready
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       ar_rem, beat_rem, out_rem, pend, len_a, len, bnd, credits;
    logic [PW:0]       count;
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic              go, ar_hs, push, pop, unused_ok;

    assign go        = start && state == IDLE;
    assign ar_hs     = arvalid_m && arready_m;
    assign push      = rvalid_m && rready_m;
    assign pop       = blk_valid && blk_ready;
    assign busy      = state == ISSUE || state == DRAIN;
    assign done      = state == FIN;
    assign rready_m  = busy;
    assign blk_valid = count != '0;
    assign blk_data  = mem[rd_ptr];
    assign blk_last  = blk_valid && out_rem == 32'd1;
    assign arid_m    = '0;
    assign arsize_m  = 3'b110;
    assign araddr_m  = addr;
    assign arlen_m   = 8'(len - 32'd1);
    assign unused_ok = ^{rid_m, rlast_m};

    // Burst length: remaining blocks, burst cap, and distance to the next 4 KB page.
    assign bnd       = 32'd64 - 32'(addr[11:6]);
    assign len_a     = ar_rem < 32'(MAX_BURST) ? ar_rem : 32'(MAX_BURST);
    assign len       = bnd < len_a ? bnd : len_a;
    assign credits   = 32'(FIFO_DEPTH) - 32'(count) - pend;
    assign arvalid_m = state == ISSUE && credits >= len;

    // DRAIN also exits on the pop of the final block so done follows it by one cycle.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = num_blocks == 32'd0 ? FIN : ISSUE;
            ISSUE:   if (ar_hs && ar_rem == len) state_nx = DRAIN;
            DRAIN:   if (out_rem == 32'd0 || (out_rem == 32'd1 && pop)) state_nx = FIN;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            addr     <= '0;
            ar_rem   <= '0;
            beat_rem <= '0;
            out_rem  <= '0;
            pend     <= '0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_err   <= 1'b0;
        end else begin
            state <= state_nx;
            if (go) begin
                addr     <= base_addr & ~ADDR_W'(63);
                ar_rem   <= num_blocks;
                beat_rem <= num_blocks;
                out_rem  <= num_blocks;
                rd_err   <= 1'b0;
            end
            if (ar_hs) begin
                addr   <= addr + (ADDR_W'(len) << 6);
                ar_rem <= ar_rem - len;
            end
            if (push) begin
                wr_ptr   <= wr_ptr + PW'(1);
                beat_rem <= beat_rem - 32'd1;
                if (rresp_m != 2'b00) rd_err <= 1'b1;
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + PW'(1);
                out_rem <= out_rem - 32'd1;
            end
            pend  <= pend + (ar_hs ? len : 32'd0) - 32'(push);
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= rdata_m;
    end

    // Credits make overflow and surplus beats impossible; flag them if they ever occur.
    always_ff @(posedge clk) begin
        if (!rst && push) assert ((count != (PW+1)'(FIFO_DEPTH) || pop) && beat_rem != 32'd0);
    end

`ifdef MD5_RD_PERF_EN
    always_ff @(posedge clk) begin
        if (rst || go) begin
            perf_ar_stall     <= '0;
            perf_credit_stall <= '0;
            perf_out_stall    <= '0;
        end else begin
            if (arvalid_m && !arready_m && perf_ar_stall != '1) perf_ar_stall <= perf_ar_stall + 32'd1;
            if (state == ISSUE && credits < len && perf_credit_stall != '1) perf_credit_stall <= perf_credit_stall + 32'd1;
            if (blk_valid && !blk_ready && perf_out_stall != '1) perf_out_stall <= perf_out_stall + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_md5_block_reader.sv
// tb_md5_block_reader: directed bench with an AXI read memory model and a block consumer.
`timescale 1ns/1ps
module tb_md5_block_reader;
    localparam int DW = 512;

    logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [63:0]   base_addr = '0;
    logic [31:0]   num_blocks = '0;
    logic          busy, done, rd_err;
    logic [15:0]   arid_m;
    logic [63:0]   araddr_m;
    logic [7:0]    arlen_m;
    logic [2:0]    arsize_m;
    logic          arvalid_m, arready_m = 1'b0;
    logic [15:0]   rid_m = '0;
    logic [DW-1:0] rdata_m = '0;
    logic [1:0]    rresp_m = '0;
    logic          rlast_m = 1'b0, rvalid_m = 1'b0, rready_m;
    logic [DW-1:0] blk_data;
    logic          blk_valid, blk_last, blk_ready = 1'b0;
`ifdef MD5_RD_PERF_EN
    logic [31:0]   perf_ar_stall, perf_credit_stall, perf_out_stall;
`endif

    int          checks = 0, errors = 0, cyc = 0;
    logic [63:0] rq[$];
    logic [63:0] ar_addr[$];
    int          ar_len[$];
    logic [63:0] exp_base = '0;
    int          exp_nb = 0, blk_idx = 0, r_idx = 0, err_beat = -1, req_beats = 0, max_out = 0;
    int          done_cnt = 0, done_cyc = 0, pop_cyc = 0, start_cyc = 0;
    logic        cons_rdy = 1'b1;

    md5_block_reader dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_blocks(num_blocks),
        .busy(busy), .done(done), .rd_err(rd_err),
        .arid_m(arid_m), .araddr_m(araddr_m), .arlen_m(arlen_m), .arsize_m(arsize_m),
        .arvalid_m(arvalid_m), .arready_m(arready_m),
        .rid_m(rid_m), .rdata_m(rdata_m), .rresp_m(rresp_m), .rlast_m(rlast_m),
        .rvalid_m(rvalid_m), .rready_m(rready_m),
        .blk_data(blk_data), .blk_valid(blk_valid), .blk_last(blk_last),
`ifdef MD5_RD_PERF_EN
        .perf_ar_stall(perf_ar_stall), .perf_credit_stall(perf_credit_stall), .perf_out_stall(perf_out_stall),
`endif
        .blk_ready(blk_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pat(input logic [63:0] a);
        logic [DW-1:0] p;
        for (int i = 0; i < 8; i++) p[64*i +: 64] = a + 64'(i);
        return p;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Memory and consumer: drive on negedge, resolve handshakes once settled.
    initial begin
        forever begin
            @(negedge clk);
            arready_m = 1'b1;
            rvalid_m  = rq.size() > 0;
            rdata_m   = rq.size() > 0 ? pat(rq[0]) : '0;
            rresp_m   = r_idx == err_beat ? 2'b10 : 2'b00;
            blk_ready = cons_rdy;
            #1;
            cyc++;
            if (rst) begin
                rq.delete();
            end else begin
                if (arvalid_m && arready_m) begin
                    ar_addr.push_back(araddr_m);
                    ar_len.push_back(int'(arlen_m));
                    for (int i = 0; i <= int'(arlen_m); i++) rq.push_back(araddr_m + 64'(64 * i));
                    req_beats += int'(arlen_m) + 1;
                end
                if (rvalid_m && rready_m) begin
                    void'(rq.pop_front());
                    r_idx++;
                end
                if (blk_valid && blk_ready) begin
                    chk("blk_data", blk_data, pat(exp_base + 64'(64 * blk_idx)));
                    chk("blk_last", blk_last, blk_idx == exp_nb - 1);
                    blk_idx++;
                    pop_cyc = cyc;
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (req_beats - blk_idx > max_out) max_out = req_beats - blk_idx;
            end
        end
    end

    task automatic start_job(input logic [63:0] b, input int n);
        @(negedge clk);
        exp_base = b & ~64'h3f;
        exp_nb = n; blk_idx = 0; r_idx = 0; req_beats = 0; max_out = 0; done_cnt = 0;
        ar_addr.delete();
        ar_len.delete();
        start = 1'b1; base_addr = b; num_blocks = n;
        #2 start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int t = 0;
        while (done_cnt == 0 && t < limit) begin
            @(negedge clk);
            t++;
        end
        chk("done_seen", done_cnt != 0, 1);
        repeat (3) @(negedge clk);
        #2;
        chk("blocks", blk_idx, exp_nb);
        chk("done_width", done_cnt, 1);
        chk("busy_after", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_err", rd_err, 0);
        chk("rst_arvalid", arvalid_m, 0);
        chk("rst_rready", rready_m, 0);
        chk("rst_blk_valid", blk_valid, 0);
        @(negedge clk) rst = 1'b0;

        start_job(64'h1000, 1);
        wait_done(200);
        chk("t1_ar_n", ar_addr.size(), 1);
        chk("t1_ar_addr", ar_addr[0], 64'h1000);
        chk("t1_ar_len", ar_len[0], 0);
        chk("t1_done_lat", done_cyc - pop_cyc, 1);
        chk("arsize", arsize_m, 3'b110);
        chk("arid", arid_m, 0);

        start_job(64'h0FC0, 130);
        wait_done(1000);
        chk("t2_ar_n", ar_addr.size(), 4);
        chk("t2_ar0", ar_addr[0], 64'h0FC0);
        chk("t2_len0", ar_len[0], 0);
        chk("t2_ar1", ar_addr[1], 64'h1000);
        chk("t2_len1", ar_len[1], 63);
        chk("t2_ar2", ar_addr[2], 64'h2000);
        chk("t2_len2", ar_len[2], 63);
        chk("t2_ar3", ar_addr[3], 64'h3000);
        chk("t2_len3", ar_len[3], 0);

        start_job(64'h5000, 0);
        wait_done(20);
        chk("t3_ar_n", ar_addr.size(), 0);
        chk("t3_done_lat", (done_cyc - start_cyc) inside {[1:2]}, 1);

        cons_rdy = 1'b0;
        start_job(64'h20000, 300);
        repeat (400) @(negedge clk);
        #2;
        chk("t4_req_beats", req_beats, 128);
        chk("t4_blk_valid", blk_valid, 1);
        chk("t4_head", blk_data, pat(64'h20000));
        cons_rdy = 1'b1;
        wait_done(3000);
        chk("t4_max_out", max_out <= 128, 1);

        err_beat = 5;
        start_job(64'h8000, 10);
        @(negedge clk);
        chk("t5_busy", busy, 1);
        start = 1'b1; base_addr = 64'h9000; num_blocks = 7;
        @(negedge clk) start = 1'b0;
        wait_done(300);
        chk("t5_rd_err", rd_err, 1);
        err_beat = -1;
        start_job(64'h1040, 2);
        #2 chk("t5_err_clr", rd_err, 0);
        wait_done(200);

        start_job(64'h40000, 200);
        for (int t = 0; t < 2000 && blk_idx < 40; t++) @(negedge clk);
        chk("t6_reached40", blk_idx >= 40, 1);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        #2;
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_rd_err", rd_err, 0);
        chk("t6_arvalid", arvalid_m, 0);
        chk("t6_rready", rready_m, 0);
        chk("t6_blk_valid", blk_valid, 0);
        start_job(64'h3021, 3);
        wait_done(200);
        chk("t6_ar_addr", ar_addr[0], 64'h3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
